// File: rtl/cam_array_if.sv
// ----------------------------------------------------------------------------
// cam_array_if
//   Command / response / result bundle between the associative-processor
//   controller and the masked CAM array.
//
//   Optional feature macro: CAM_MATCH_COUNT_EN adds the match_count signal.
//
//   Signals:
//     cmd_valid   command present (controller -> CAM)
//     cmd_ready   CAM accepts the command this cycle
//     cmd_op      3-bit opcode
//     cmd_addr    row address for WRITE/READ
//     cmd_data    write data
//     cmd_key     compare key
//     cmd_mask    active-bit mask for write and compare
//     rsp_valid   one-cycle pulse, rsp_data holds a READ result
//     rsp_data    READ result
//     tags        registered per-row tag bits
//     any_match   OR of all tags
//     first_idx   lowest row index with its tag set, 0 if none
//     match_count number of set tags (CAM_MATCH_COUNT_EN only)
//
//   Modports: master = controller side, slave = CAM side.
// ----------------------------------------------------------------------------
interface cam_array_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 4
);
    localparam int unsigned ROWS = 2 ** ADDR_BITS;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [WIDTH-1:0]     cmd_data;
    logic [WIDTH-1:0]     cmd_key;
    logic [WIDTH-1:0]     cmd_mask;
    logic                 rsp_valid;
    logic [WIDTH-1:0]     rsp_data;
    logic [ROWS-1:0]      tags;
    logic                 any_match;
    logic [ADDR_BITS-1:0] first_idx;
`ifdef CAM_MATCH_COUNT_EN
    logic [ADDR_BITS:0]   match_count;
`endif

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_data,
        output cmd_key,
        output cmd_mask,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data,
        input  tags,
        input  any_match,
        input  first_idx
`ifdef CAM_MATCH_COUNT_EN
        ,
        input  match_count
`endif
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_data,
        input  cmd_key,
        input  cmd_mask,
        output cmd_ready,
        output rsp_valid,
        output rsp_data,
        output tags,
        output any_match,
        output first_idx
`ifdef CAM_MATCH_COUNT_EN
        ,
        output match_count
`endif
    );

endinterface

// File: rtl/cam_array.sv
// ----------------------------------------------------------------------------
// cam_array
//   Multi-row masked CAM for the associative processor. Holds ROWS words of
//   WIDTH bits plus one tag bit per row. Supports single-row masked write and
//   read, parallel masked compare into the tags, tag-AND compare for
//   multi-pass searches, parallel tagged write and a full-array clear.
//
//   Optional feature macro: CAM_MATCH_COUNT_EN enables the match_count output
//   (popcount of the tags, ADDR_BITS+1 bits wide). Without it the popcount
//   logic and the port are absent; everything else is identical.
//
//   Ports:
//     clka  clock, all logic on the rising edge
//     rst   synchronous, active-low reset
//     bus   cam_array_if slave modport (command, READ response, tag results)
//
//   Opcodes: 0 NOP, 1 WRITE, 2 READ, 3 COMPARE, 4 TAG_AND, 5 TAG_WRITE,
//            6 CLEAR, 7 reserved (no effect).
//
//   The memory has no reset; after reset (or a CLEAR command) the array sits
//   in the clear state for ROWS cycles zeroing one row per cycle, and the
//   command port is not ready during that time.
// ----------------------------------------------------------------------------
module cam_array #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 4
) (
    input logic         clka,
    input logic         rst,
    cam_array_if.slave  bus
);

    localparam int unsigned ROWS = 2 ** ADDR_BITS;

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    typedef enum logic [2:0] {
        OpNop      = 3'd0,
        OpWrite    = 3'd1,
        OpRead     = 3'd2,
        OpCompare  = 3'd3,
        OpTagAnd   = 3'd4,
        OpTagWrite = 3'd5,
        OpClear    = 3'd6,
        OpRsvd     = 3'd7
    } op_e;

    // State and storage
    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic [ROWS-1:0]      tags_q, tags_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0]     mem_q [ROWS];
    logic [WIDTH-1:0]     mem_d [ROWS];

    logic                 accept;
    logic [ROWS-1:0]      cmp_hit;
    op_e                  op;

    // Masked merge: bits with mask=1 take new data, others keep the old value.
    function automatic logic [WIDTH-1:0] masked_merge(
        input logic [WIDTH-1:0] old_val,
        input logic [WIDTH-1:0] new_val,
        input logic [WIDTH-1:0] mask
    );
        return (new_val & mask) | (old_val & ~mask);
    endfunction

    assign bus.cmd_ready = (state_q == StIdle);
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign op            = op_e'(bus.cmd_op);

    // Per-row compare against the current (pre-write) memory contents.
    always_comb begin
        cmp_hit = '0;
        for (int i = 0; i < ROWS; i++) begin
            cmp_hit[i] = (((mem_q[i] ^ bus.cmd_key) & bus.cmd_mask) == '0);
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        tags_d      = tags_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < ROWS; i++) begin
            mem_d[i] = mem_q[i];
        end

        unique case (state_q)
            StClear: begin
                mem_d[clr_cnt_q] = '0;
                clr_cnt_d        = clr_cnt_q + ADDR_BITS'(1);
                if (clr_cnt_q == ADDR_BITS'(ROWS - 1)) begin
                    state_d = StIdle;
                end
            end

            StIdle: begin
                if (accept) begin
                    case (op)
                        OpWrite: begin
                            mem_d[bus.cmd_addr] = masked_merge(mem_q[bus.cmd_addr],
                                                               bus.cmd_data, bus.cmd_mask);
                        end
                        OpRead: begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = mem_q[bus.cmd_addr];
                        end
                        OpCompare: begin
                            tags_d = cmp_hit;
                        end
                        OpTagAnd: begin
                            tags_d = tags_q & cmp_hit;
                        end
                        OpTagWrite: begin
                            for (int i = 0; i < ROWS; i++) begin
                                if (tags_q[i]) begin
                                    mem_d[i] = masked_merge(mem_q[i], bus.cmd_data,
                                                            bus.cmd_mask);
                                end
                            end
                        end
                        OpClear: begin
                            state_d   = StClear;
                            clr_cnt_d = '0;
                            tags_d    = '0;
                        end
                        default: ;  // NOP and reserved opcode
                    endcase
                end
            end

            default: begin
                state_d   = StClear;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clka) begin
        if (!rst) begin
            state_q     <= StClear;
            clr_cnt_q   <= '0;
            tags_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            tags_q      <= tags_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Storage array: never reset directly, frozen while reset is asserted.
    always_ff @(posedge clka) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Tag-derived outputs, combinational from the registered tags
    logic [ADDR_BITS-1:0] first_idx;

    always_comb begin
        first_idx = '0;
        // Scan downward so the lowest set index wins.
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (tags_q[i]) begin
                first_idx = ADDR_BITS'(i);
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.tags      = tags_q;
    assign bus.any_match = |tags_q;
    assign bus.first_idx = first_idx;

`ifdef CAM_MATCH_COUNT_EN
    localparam int unsigned CntW = ADDR_BITS + 1;

    logic [CntW-1:0] match_count;

    always_comb begin
        match_count = '0;
        for (int i = 0; i < ROWS; i++) begin
            match_count = match_count + CntW'(tags_q[i]);
        end
    end

    assign bus.match_count = match_count;
`endif

endmodule

// File: tb/tb_cam_array.sv
// ----------------------------------------------------------------------------
// tb_cam_array
//   Self-checking bench for cam_array. Stimulus updates a behavioural model of
//   the array on every accepted command and queues the expected READ data and
//   expected tag vectors; a monitor on the falling clock edge pops and compares
//   them against the DUT outputs. Optional macro: CAM_MATCH_COUNT_EN.
// ----------------------------------------------------------------------------
module tb_cam_array;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned ADDR_BITS = 4;
    localparam int unsigned ROWS      = 16;

    logic clka = 1'b0;
    logic rst  = 1'b0;

    always #5 clka = ~clka;

    cam_array_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus ();

    cam_array #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    // Reference model and scoreboard
    logic [7:0]  m_mem [ROWS];
    logic [15:0] m_tags;
    logic [7:0]  rq [$];
    logic [15:0] tq [$];
    logic [15:0] t_exp;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [15:0] t);
        for (int i = 0; i < 16; i++) begin
            if (t[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [15:0] match_vec(input logic [7:0] key, input logic [7:0] mask);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v[i] = (((m_mem[i] ^ key) & mask) == 8'h00);
        end
        return v;
    endfunction

    // Apply one accepted command to the model and queue expectations.
    task automatic model_apply(input logic [2:0] op, input logic [3:0] addr,
                               input logic [7:0] data, input logic [7:0] key,
                               input logic [7:0] mask);
        case (op)
            3'd1: m_mem[addr] = (data & mask) | (m_mem[addr] & ~mask);
            3'd2: rq.push_back(m_mem[addr]);
            3'd3: begin
                m_tags = match_vec(key, mask);
                tq.push_back(m_tags);
            end
            3'd4: begin
                m_tags = m_tags & match_vec(key, mask);
                tq.push_back(m_tags);
            end
            3'd5: begin
                for (int i = 0; i < 16; i++) begin
                    if (m_tags[i]) m_mem[i] = (data & mask) | (m_mem[i] & ~mask);
                end
            end
            3'd6: begin
                for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
                m_tags = 16'h0000;
                tq.push_back(m_tags);
            end
            default: ;
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] addr,
                         input logic [7:0] data, input logic [7:0] key,
                         input logic [7:0] mask);
        int w = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        bus.cmd_key   = key;
        bus.cmd_mask  = mask;
        while (bus.cmd_ready !== 1'b1 && w < 64) begin
            @(posedge clka);
            #1;
            w++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clka);
        model_apply(op, addr, data, key, mask);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Hold reset, check reset outputs, release and measure the not-ready window.
    task automatic do_reset(input int hold);
        int n = 0;
        rst = 1'b0;
        repeat (hold) @(posedge clka);
        @(negedge clka);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_tags", 32'(bus.tags), 32'd0);
        check("rst_any_match", 32'(bus.any_match), 32'd0);
        check("rst_first_idx", 32'(bus.first_idx), 32'd0);
`ifdef CAM_MATCH_COUNT_EN
        check("rst_match_count", 32'(bus.match_count), 32'd0);
`endif
        @(posedge clka);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_tags = 16'h0000;
        while (n < 100) begin
            @(negedge clka);
            if (bus.cmd_ready === 1'b1) break;
            n++;
        end
        check("clear_ready_low_cycles", 32'(n), 32'd16);
        @(posedge clka);
        #1;
    endtask

    // Monitor: compare DUT outputs against queued expectations
    always @(negedge clka) begin
        if (bus.rsp_valid === 1'b1) begin
            if (rq.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
            else check("rsp_data", 32'(bus.rsp_data), 32'(rq.pop_front()));
        end else if (rq.size() != 0) begin
            void'(rq.pop_front());
            check("rsp_missing", 32'(bus.rsp_valid), 32'd1);
        end
        if (tq.size() != 0) begin
            t_exp = tq.pop_front();
            check("tags", 32'(bus.tags), 32'(t_exp));
            check("any_match", 32'(bus.any_match), 32'(|t_exp));
            check("first_idx", 32'(bus.first_idx), 32'(lowest_set(t_exp)));
`ifdef CAM_MATCH_COUNT_EN
            check("match_count", 32'(bus.match_count), 32'($countones(t_exp)));
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] key;
        logic [7:0] mask;
        int r;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_key   = '0;
        bus.cmd_mask  = '0;
        m_tags        = 16'h0000;

        // Reset, then read an arbitrary row
        do_reset(3);
        issue(3'd2, 4'd11, 8'h00, 8'h00, 8'h00);

        // Masked write and read-back
        issue(3'd1, 4'd3, 8'hA5, 8'h00, 8'hFF);
        issue(3'd1, 4'd3, 8'h00, 8'h00, 8'h0F);
        issue(3'd2, 4'd3, 8'h00, 8'h00, 8'h00);
        @(negedge clka);
        check("read_a0_valid", 32'(bus.rsp_valid), 32'd1);
        check("read_a0_data", 32'(bus.rsp_data), 32'hA0);
        @(negedge clka);
        check("read_pulse_one_cycle", 32'(bus.rsp_valid), 32'd0);
        @(posedge clka);
        #1;

        // Compare, then tag-AND refine
        issue(3'd1, 4'd2, 8'h3C, 8'h00, 8'hFF);
        issue(3'd1, 4'd5, 8'h3F, 8'h00, 8'hFF);
        issue(3'd1, 4'd9, 8'h7C, 8'h00, 8'hFF);
        issue(3'd3, 4'd0, 8'h00, 8'h3C, 8'hF0);
        check("cmp_tags", 32'(bus.tags), 32'h0024);
        check("cmp_first_idx", 32'(bus.first_idx), 32'd2);
        check("cmp_any_match", 32'(bus.any_match), 32'd1);
`ifdef CAM_MATCH_COUNT_EN
        check("cmp_match_count", 32'(bus.match_count), 32'd2);
`endif
        issue(3'd4, 4'd0, 8'h00, 8'h0F, 8'h0F);
        check("tagand_tags", 32'(bus.tags), 32'h0020);
        check("tagand_first_idx", 32'(bus.first_idx), 32'd5);

        // Tagged write only hits row 5
        issue(3'd5, 4'd0, 8'h00, 8'h00, 8'hFF);
        issue(3'd2, 4'd5, 8'h00, 8'h00, 8'h00);
        issue(3'd2, 4'd2, 8'h00, 8'h00, 8'h00);

        // Clear array, then a compare that cannot hit
        issue(3'd6, 4'd0, 8'h00, 8'h00, 8'h00);
        issue(3'd3, 4'd0, 8'h00, 8'hFF, 8'hFF);
        check("nomatch_any", 32'(bus.any_match), 32'd0);
        check("nomatch_first_idx", 32'(bus.first_idx), 32'd0);

        // Fill with 0xFF, CLEAR, reset in the middle of the clear sequence
        for (int i = 0; i < 16; i++) issue(3'd1, 4'(i), 8'hFF, 8'h00, 8'hFF);
        issue(3'd6, 4'd0, 8'h00, 8'h00, 8'h00);
        repeat (7) @(posedge clka);
        #1;
        do_reset(2);
        for (int i = 0; i < 16; i++) issue(3'd2, 4'(i), 8'h00, 8'h00, 8'h00);

        // Mask 0 matches every row
        issue(3'd1, 4'd7, 8'h5A, 8'h00, 8'hFF);
        issue(3'd3, 4'd0, 8'h00, 8'h81, 8'h00);
        check("mask0_tags", 32'(bus.tags), 32'hFFFF);
`ifdef CAM_MATCH_COUNT_EN
        check("mask0_match_count", 32'(bus.match_count), 32'd16);
`endif

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 99);
            mask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 1) == 1) key = m_mem[$urandom_range(0, 15)];
            else key = 8'($urandom);
            if (r < 25)      issue(3'd1, 4'($urandom), 8'($urandom), 8'h00, mask);
            else if (r < 45) issue(3'd2, 4'($urandom), 8'h00, 8'h00, 8'h00);
            else if (r < 65) issue(3'd3, 4'd0, 8'h00, key, mask);
            else if (r < 80) issue(3'd4, 4'd0, 8'h00, key, mask);
            else if (r < 90) issue(3'd5, 4'd0, 8'($urandom), 8'h00, mask);
            else if (r < 92) issue(3'd6, 4'd0, 8'h00, 8'h00, 8'h00);
            else if (r < 96) issue(3'd0, 4'($urandom), 8'($urandom), key, mask);
            else             issue(3'd7, 4'($urandom), 8'($urandom), key, mask);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clka);
                #1;
            end
        end

        // Final sweep of the whole array against the model
        for (int i = 0; i < 16; i++) issue(3'd2, 4'(i), 8'h00, 8'h00, 8'h00);

        repeat (3) @(posedge clka);
        check("queues_drained", 32'(rq.size() + tq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
